mem_port_ctrl: RTL and testbench

Request-sequencing front end that sits directly upstream of the single-port word memory model. It accepts read/write requests over a valid/ready handshake and buffers them in a small in-order FIFO. It drives the memory's registered port one access at a time and returns read data over a second valid/ready handshake. Out-of-range addresses are trapped here, so the memory only ever sees legal indices.

---
 rtl/mem_ctrl_pkg.sv | 30 +++
 rtl/mem_port_ctrl_if.sv | 35 +++
 rtl/mem_req_fifo.sv | 53 +++++
 rtl/mem_port_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_port_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the memory port controller.
// Request layout, FSM states and the address range check.
package mem_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SIZE       = 1000;
    localparam int DEF_ADDR_W     = $clog2(DEF_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_e;

    typedef struct packed {
        logic                      write;
        logic [DEF_ADDR_W-1:0]     addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } req_def_t;

    // SIZE need not be a power of two, so the top of the index space is illegal.
    function automatic logic addr_legal(
        input logic [31:0] addr,
        input logic [31:0] size
    );
        return addr < size;
    endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Request, response and memory-port signals of the controller.
// slave = controller view, master = requester/memory view.
interface mem_port_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_data,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_data,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_req_fifo.sv
// Synchronous in-order FIFO holding pending memory requests.
// DEPTH is a power of two so the pointers wrap naturally.
module mem_req_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  T                             i_data,
    input  logic                         i_pop,
    output T                             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/mem_port_ctrl.sv
// Request sequencer in front of a registered single-port word memory:
// in-order FIFO, range trapping, one access at a time, read responses.
module mem_port_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 1000,
    parameter int DEPTH      = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_port_ctrl_if.slave bus
);
    localparam int ADDR_W = $clog2(SIZE);
    localparam int CW     = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                  write;
        logic [ADDR_W-1:0]     addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    req_t                  w_req;
    req_t                  w_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;

    state_e                r_state;
    state_e                w_state_nx;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;
    logic                  w_mem_en_nx;
    logic                  w_mem_we_nx;
    logic [ADDR_W-1:0]     w_mem_addr_nx;
    logic [DATA_WIDTH-1:0] w_mem_wdata_nx;
    logic [DATA_WIDTH-1:0] w_rsp_data_nx;
    logic                  w_rsp_err_nx;

    assign w_req.write = bus.req_write;
    assign w_req.addr  = bus.req_addr;
    assign w_req.data  = bus.req_data;
    assign w_push      = bus.req_valid && bus.req_ready;

    mem_req_fifo #(
        .DEPTH (DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    a_count_empty: assert property (
        @(posedge clk) disable iff (rst) w_empty == (w_count == '0)
    );

    always_comb begin
        w_state_nx     = r_state;
        w_pop          = 1'b0;
        w_mem_en_nx    = 1'b0;
        w_mem_we_nx    = r_mem_we;
        w_mem_addr_nx  = r_mem_addr;
        w_mem_wdata_nx = r_mem_wdata;
        w_rsp_data_nx  = r_rsp_data;
        w_rsp_err_nx   = r_rsp_err;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (addr_legal(32'(w_head.addr), 32'(SIZE))) begin
                        w_mem_en_nx    = 1'b1;
                        w_mem_we_nx    = w_head.write;
                        w_mem_addr_nx  = w_head.addr;
                        w_mem_wdata_nx = w_head.data;
                        w_state_nx     = ISSUE;
                    end else if (!w_head.write) begin
                        w_rsp_data_nx = '0;
                        w_rsp_err_nx  = 1'b1;
                        w_state_nx    = RESP;
                    end
                end
            end
            ISSUE: begin
                w_state_nx = r_mem_we ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                w_rsp_data_nx = bus.mem_rdata;
                w_rsp_err_nx  = 1'b0;
                w_state_nx    = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_mem_en    <= w_mem_en_nx;
            r_mem_we    <= w_mem_we_nx;
            r_mem_addr  <= w_mem_addr_nx;
            r_mem_wdata <= w_mem_wdata_nx;
            r_rsp_data  <= w_rsp_data_nx;
            r_rsp_err   <= w_rsp_err_nx;
        end
    end

    assign bus.req_ready = !w_full && !rst;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: word memory model, transaction-level reference
// (requests applied in acceptance order), directed cases plus random traffic.
module tb_mem_port_ctrl;
    localparam int DW   = 32;
    localparam int SIZE = 1000;
    localparam int AW   = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_ctrl_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

    mem_port_ctrl #(
        .DATA_WIDTH (DW),
        .SIZE       (SIZE),
        .DEPTH      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rise_cyc = 0;
    int rsp_cnt = 0;
    int en_cnt = 0;
    int exp_en = 0;
    logic [31:0] tmem [SIZE];
    logic [31:0] refm [SIZE];
    logic [32:0] expq [$];
    logic [31:0] last_d = '0;
    logic        last_e = 1'b0;
    logic [31:0] hold_d = '0;
    logic        hold_e = 1'b0;
    logic        stall_p = 1'b0;
    logic        prev_v = 1'b0;
    bit          done = 1'b0;

    function automatic logic [31:0] seed_word(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h00C0FFEE;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory driven by the DUT's registered port.
    always @(posedge clk) begin
        if (bus.mem_en && int'(bus.mem_addr) < SIZE) begin
            if (bus.mem_we) tmem[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata <= tmem[bus.mem_addr];
        end
    end

    // Reference model and per-cycle compare.
    always @(negedge clk) begin
        int a;
        logic [32:0] e;
        if (rst) begin
            expq.delete();
            stall_p = 1'b0;
            prev_v  = 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                a = int'(bus.req_addr);
                acc_cyc = cyc;
                if (a < SIZE) begin
                    exp_en++;
                    if (bus.req_write) refm[a] = bus.req_data;
                    else expq.push_back({1'b0, refm[a]});
                end else if (!bus.req_write) begin
                    expq.push_back({1'b1, 32'h0});
                end
            end
            if (bus.rsp_valid && !prev_v) rise_cyc = cyc;
            if (stall_p) begin
                chk("rsp_hold_valid", 64'(bus.rsp_valid), 64'(1));
                chk("rsp_hold_data", 64'(bus.rsp_data), 64'(hold_d));
                chk("rsp_hold_err", 64'(bus.rsp_err), 64'(hold_e));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("rsp_expected", 64'(expq.size() != 0), 64'(1));
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("rsp_data", 64'(bus.rsp_data), 64'(e[31:0]));
                    chk("rsp_err", 64'(bus.rsp_err), 64'(e[32]));
                end
                last_d = bus.rsp_data;
                last_e = bus.rsp_err;
                rsp_cnt++;
            end
            if (bus.mem_en) begin
                en_cnt++;
                chk("mem_addr_legal", 64'(int'(bus.mem_addr) < SIZE), 64'(1));
            end
            stall_p = bus.rsp_valid && !bus.rsp_ready;
            hold_d  = bus.rsp_data;
            hold_e  = bus.rsp_err;
            prev_v  = bus.rsp_valid;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input bit w, input int a, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = AW'(a);
        bus.req_data  = d;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = bus.req_ready;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        chk("req_accept", 64'(ok), 64'(1));
    endtask

    task automatic wait_rsp(input int target);
        for (int t = 0; t < 100 && rsp_cnt < target; t++) idle(1);
        chk("rsp_arrive", 64'(rsp_cnt >= target), 64'(1));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
        chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'(0));
        chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'(0));
        chk({tag, "_mem_en"}, 64'(bus.mem_en), 64'(0));
        chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'(0));
        chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(0));
        chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
    endtask

    initial begin
        int b;
        int e0;
        int nbad;
        bit rv;
        for (int i = 0; i < SIZE; i++) begin
            tmem[i] = seed_word(i);
            refm[i] = seed_word(i);
        end
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        bus.mem_rdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(bus.req_ready), 64'(1));
        @(posedge clk);
        #1;

        // Write then read back, with accept-to-response latency.
        send(1'b1, 'h34, 32'h98798798);
        idle(5);
        b = rsp_cnt;
        send(1'b0, 'h34, 32'h0);
        wait_rsp(b + 1);
        chk("lat_data", 64'(last_d), 64'h98798798);
        chk("lat_err", 64'(last_e), 64'(0));
        chk("lat_cycles", 64'(rise_cyc - acc_cyc), 64'(4));

        // Out-of-range read and write.
        idle(3);
        e0 = en_cnt;
        b = rsp_cnt;
        send(1'b0, 1000, 32'h0);
        send(1'b1, 1023, 32'hDEADBEEF);
        wait_rsp(b + 1);
        idle(4);
        chk("oor_data", 64'(last_d), 64'(0));
        chk("oor_err", 64'(last_e), 64'(1));
        chk("oor_no_mem_en", 64'(en_cnt - e0), 64'(0));

        // Stalled response fills the FIFO.
        bus.rsp_ready = 1'b0;
        b = rsp_cnt;
        for (int i = 0; i < 5; i++) send(1'b0, 10 + i, 32'h0);
        @(negedge clk);
        chk("full_ready_low", 64'(bus.req_ready), 64'(0));
        chk("full_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        chk("full_head_data", 64'(bus.rsp_data), 64'(seed_word(10)));
        @(posedge clk);
        #1;
        idle(3);
        bus.rsp_ready = 1'b1;
        wait_rsp(b + 5);
        chk("full_last_data", 64'(last_d), 64'(seed_word(14)));
        @(negedge clk);
        chk("full_ready_back", 64'(bus.req_ready), 64'(1));
        @(posedge clk);
        #1;

        // Read directly behind a write to the same word.
        b = rsp_cnt;
        send(1'b1, 5, 32'h11);
        send(1'b0, 5, 32'h0);
        wait_rsp(b + 1);
        chk("raw_data", 64'(last_d), 64'h11);
        idle(3);

        // Reset while a read is in CAPTURE.
        b = rsp_cnt;
        send(1'b0, 20, 32'h0);
        idle(2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", 64'(bus.req_ready), 64'(1));
        rv = 1'b0;
        repeat (8) begin
            @(negedge clk);
            rv = rv | bus.rsp_valid;
        end
        chk("midrst_no_rsp", 64'(rv), 64'(0));
        chk("midrst_rsp_count", 64'(rsp_cnt), 64'(b));
        @(posedge clk);
        #1;

        // Random traffic with random back-pressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int r;
                    int a;
                    r = int'($urandom_range(0, 9));
                    if (r == 0)     a = int'($urandom_range(1000, 1023));
                    else if (r < 6) a = int'($urandom_range(0, 15));
                    else            a = int'($urandom_range(0, 999));
                    send(1'($urandom_range(0, 1)), a, $urandom);
                    if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.rsp_ready = 1'($urandom_range(0, 1));
                    idle(1);
                end
            end
        join
        bus.rsp_ready = 1'b1;
        for (int t = 0; t < 200 && expq.size() != 0; t++) idle(1);
        idle(6);
        chk("drain_empty", 64'(expq.size()), 64'(0));
        chk("mem_en_count", 64'(en_cnt), 64'(exp_en));
        nbad = 0;
        for (int i = 0; i < SIZE; i++) if (tmem[i] !== refm[i]) nbad++;
        chk("mem_image", 64'(nbad), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
